// File: rtl/key_inject_sched_if.sv
// Injection request channel for key_inject_sched.
// master: the block issuing synthetic key requests.
// slave: key_inject_sched itself.
interface key_inject_sched_if;
  logic       inj_valid;  // request valid
  logic       inj_ready;  // FIFO not full
  logic [7:0] inj_code;   // scancode to inject
  logic       inj_ext;    // extended flag for inj_code
  logic       inj_shift;  // wrap the key in a left-shift press/release
  logic       inj_flush;  // drop queued requests, finish current key

  modport master (
    output inj_valid,
    output inj_code,
    output inj_ext,
    output inj_shift,
    output inj_flush,
    input  inj_ready
  );

  modport slave (
    input  inj_valid,
    input  inj_code,
    input  inj_ext,
    input  inj_shift,
    input  inj_flush,
    output inj_ready
  );
endinterface

// File: rtl/key_inject_sched.sv
// key_inject_sched: merges live PS/2 host events with queued synthetic key
// presses. Each injected key is pressed, held for HOLD_CYCLES, released,
// then followed by GAP_CYCLES of quiet. Host events always win a cycle.
// Event format on host_key/out_key: [7:0] code, [8] ext, [9] pressed,
// [10] toggles once per event.
// Build option: define KEY_INJ_SHIFT_EN to honour inj_shift (left-shift
// 0x12 wrapped around the key); otherwise inj_shift is ignored.
module key_inject_sched #(
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES  = 500000
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [10:0]        host_key,
  key_inject_sched_if.slave  inj,
  output logic [10:0]        out_key,
  output logic               busy
);

  localparam logic [23:0] HOLD_LD  = 24'(HOLD_CYCLES);
  localparam logic [23:0] GAP_LD   = 24'(GAP_CYCLES);
  localparam logic [7:0]  LSHIFT   = 8'h12;

`ifdef KEY_INJ_SHIFT_EN
  localparam int unsigned FW = 10;  // {shift, ext, code}
`else
  localparam int unsigned FW = 9;   // {ext, code}
`endif

  typedef enum logic [2:0] {
    IDLE,
    SHDN,
    KDN,
    HOLD,
    KUP,
    SHUP,
    GAP
  } state_t;

  // ---------------------------------------------------------------------
  // Request FIFO (8 entries)
  // ---------------------------------------------------------------------
  logic [FW-1:0] fifo_mem [8];
  logic [2:0]    wr_ptr;
  logic [2:0]    rd_ptr;
  logic [3:0]    count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [FW-1:0] wr_data;
  logic [FW-1:0] head;

  assign fifo_full     = (count == 4'd8);
  assign fifo_empty    = (count == 4'd0);
  assign inj.inj_ready = ~fifo_full;
  // A flush in the same cycle discards the incoming request as well.
  assign push          = inj.inj_valid & ~fifo_full & ~inj.inj_flush;
  assign head          = fifo_mem[rd_ptr];

`ifdef KEY_INJ_SHIFT_EN
  assign wr_data = {inj.inj_shift, inj.inj_ext, inj.inj_code};
`else
  logic unused_shift;
  assign unused_shift = inj.inj_shift;
  assign wr_data      = {inj.inj_ext, inj.inj_code};
`endif

  // FIFO storage write; contents need no reset, the pointers qualify them.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue immediately.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (inj.inj_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Host event detection
  // ---------------------------------------------------------------------
  logic host_tgl_q;
  logic host_primed;
  logic host_evt;

  // Track host toggle bit; the first cycle after reset only primes the copy.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      host_tgl_q  <= 1'b0;
      host_primed <= 1'b0;
    end else begin
      host_tgl_q  <= host_key[10];
      host_primed <= 1'b1;
    end
  end

  assign host_evt = host_primed & (host_key[10] ^ host_tgl_q);

  // ---------------------------------------------------------------------
  // Injection FSM
  // ---------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [23:0] timer;
  logic [23:0] timer_nxt;
  logic [7:0]  lat_code;
  logic        lat_ext;
`ifdef KEY_INJ_SHIFT_EN
  logic        lat_shift;
`endif

  logic        emit_en;
  logic        emit_pressed;
  logic        emit_ext;
  logic [7:0]  emit_code;

  // State, timer and latched request registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      lat_code  <= '0;
      lat_ext   <= 1'b0;
`ifdef KEY_INJ_SHIFT_EN
      lat_shift <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (pop) begin
        lat_code  <= head[7:0];
        lat_ext   <= head[8];
`ifdef KEY_INJ_SHIFT_EN
        lat_shift <= head[9];
`endif
      end
    end
  end

  // Next-state, timer and emit decode. A host event freezes the FSM for the
  // cycle; a flush while a press may be outstanding jumps straight to KUP
  // (that jump emits nothing, so it does not need to wait for the host).
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    pop          = 1'b0;
    emit_en      = 1'b0;
    emit_pressed = 1'b0;
    emit_ext     = 1'b0;
    emit_code    = '0;

    if (inj.inj_flush && (state == SHDN || state == KDN || state == HOLD)) begin
      state_nxt = KUP;
      timer_nxt = '0;
    end else if (!host_evt) begin
      case (state)
        IDLE: begin
          // The head is discarded by a flush, so never pop alongside one.
          if (!fifo_empty && !inj.inj_flush) begin
            pop = 1'b1;
`ifdef KEY_INJ_SHIFT_EN
            state_nxt = head[9] ? SHDN : KDN;
`else
            state_nxt = KDN;
`endif
          end
        end
        SHDN: begin
          emit_en      = 1'b1;
          emit_pressed = 1'b1;
          emit_code    = LSHIFT;
          state_nxt    = KDN;
        end
        KDN: begin
          emit_en      = 1'b1;
          emit_pressed = 1'b1;
          emit_ext     = lat_ext;
          emit_code    = lat_code;
          timer_nxt    = HOLD_LD;
          state_nxt    = HOLD;
        end
        HOLD: begin
          if (timer <= 24'd1) begin
            timer_nxt = '0;
            state_nxt = KUP;
          end else begin
            timer_nxt = timer - 24'd1;
          end
        end
        KUP: begin
          emit_en   = 1'b1;
          emit_ext  = lat_ext;
          emit_code = lat_code;
`ifdef KEY_INJ_SHIFT_EN
          if (lat_shift) begin
            state_nxt = SHUP;
          end else begin
            state_nxt = GAP;
            timer_nxt = GAP_LD;
          end
`else
          state_nxt = GAP;
          timer_nxt = GAP_LD;
`endif
        end
        SHUP: begin
          emit_en   = 1'b1;
          emit_code = LSHIFT;
          state_nxt = GAP;
          timer_nxt = GAP_LD;
        end
        GAP: begin
          if (timer <= 24'd1) begin
            timer_nxt = '0;
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - 24'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Merged output stream
  // ---------------------------------------------------------------------
  // Host events are forwarded first; injected events fill the other cycles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_key <= '0;
    end else if (host_evt) begin
      out_key <= {~out_key[10], host_key[9:0]};
    end else if (emit_en) begin
      out_key <= {~out_key[10], emit_pressed, emit_ext, emit_code};
    end
  end

  assign busy = ~fifo_empty | (state != IDLE);

endmodule

// File: tb/tb_key_inject_sched.sv
// Scoreboard bench for key_inject_sched (HOLD_CYCLES=4, GAP_CYCLES=2).
// Expected output events, with the edge they must appear on, are queued as
// stimulus is set up; a monitor pops and compares each change of out_key.
module tb_key_inject_sched;

  logic        clk_sys;
  logic        reset_n;
  logic [10:0] host_key;
  logic [10:0] out_key;
  logic        busy;

  key_inject_sched_if bus();

  key_inject_sched #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .host_key(host_key),
    .inj     (bus.slave),
    .out_key (out_key),
    .busy    (busy)
  );

  typedef struct {
    logic [10:0] key;
    int          cyc;
  } ev_t;

  ev_t         sbq[$];
  ev_t         mon_ev;
  logic [10:0] mon_prev;
  logic        exp_tgl;
  int          cyc;
  int          n_tests;
  int          n_fail;
  int          e0;
  int          acc;
  logic [7:0]  cd;

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Queue one expected output event; the model toggle flips per event.
  task automatic exp_ev(input logic [9:0] d, input int c);
    exp_tgl = ~exp_tgl;
    sbq.push_back('{key: {exp_tgl, d}, cyc: c});
  endtask

  // Hold the current request until accepted; returns the accepting edge.
  task automatic push_wait(output int a);
    logic rdy;
    int   n;
    n = 0;
    do begin
      rdy = bus.inj_ready;
      tick();
      n++;
    end while (!rdy && n < 40);
    if (!rdy) chk("push_timeout", 32'(rdy), 32'd1);
    a = cyc;
  endtask

  task automatic drive_push(input logic [7:0] code, input logic ext, input logic sh);
    bus.inj_valid = 1'b1;
    bus.inj_code  = code;
    bus.inj_ext   = ext;
    bus.inj_shift = sh;
  endtask

  // Monitor: every change of out_key must match the scoreboard head.
  always @(posedge clk_sys) begin
    #2;
    if (!reset_n) begin
      mon_prev = out_key;
    end else if (out_key !== mon_prev) begin
      mon_prev = out_key;
      if (sbq.size() == 0) begin
        chk("sb_unexpected_event", 32'(sbq.size()), 32'd1);
      end else begin
        mon_ev = sbq.pop_front();
        chk("ev_key", 32'(out_key), 32'(mon_ev.key));
        chk("ev_cycle", 32'(cyc), 32'(mon_ev.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_tgl = 1'b0;
    mon_prev = '0;
    reset_n = 1'b0;
    host_key = 11'h400;
    bus.inj_valid = 1'b0;
    bus.inj_code  = '0;
    bus.inj_ext   = 1'b0;
    bus.inj_shift = 1'b0;
    bus.inj_flush = 1'b0;

    // Reset state, host toggle bit already high at release
    repeat (3) tick();
    chk("rst_out_key", 32'(out_key), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.inj_ready), 32'd1);
    reset_n = 1'b1;
    repeat (6) tick();
    chk("rst_no_host_event", 32'(out_key), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);

    // Plain key: press after E2, release after E7
    e0 = cyc + 1;
    exp_ev({1'b1, 1'b0, 8'h1C}, e0 + 2);
    exp_ev({1'b0, 1'b0, 8'h1C}, e0 + 7);
    drive_push(8'h1C, 1'b0, 1'b0);
    tick();
    bus.inj_valid = 1'b0;
    wait_cyc(e0 + 8);
    chk("t1_busy_in_gap", 32'(busy), 32'd1);
    wait_cyc(e0 + 11);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_drain", 32'(sbq.size()), 32'd0);

    // Shift-wrapped request
    e0 = cyc + 1;
`ifdef KEY_INJ_SHIFT_EN
    exp_ev({1'b1, 1'b0, 8'h12}, e0 + 2);
    exp_ev({1'b1, 1'b0, 8'h1C}, e0 + 3);
    exp_ev({1'b0, 1'b0, 8'h1C}, e0 + 8);
    exp_ev({1'b0, 1'b0, 8'h12}, e0 + 9);
`else
    exp_ev({1'b1, 1'b0, 8'h1C}, e0 + 2);
    exp_ev({1'b0, 1'b0, 8'h1C}, e0 + 7);
`endif
    drive_push(8'h1C, 1'b0, 1'b1);
    tick();
    bus.inj_valid = 1'b0;
    bus.inj_shift = 1'b0;
    wait_cyc(e0 + 14);
    chk("t2_busy_done", 32'(busy), 32'd0);
    chk("t2_drain", 32'(sbq.size()), 32'd0);

    // Host toggle in the KDN cycle: host first, press one edge later
    e0 = cyc + 1;
    exp_ev(10'h21B, e0 + 2);
    exp_ev({1'b1, 1'b1, 8'h75}, e0 + 3);
    exp_ev({1'b0, 1'b1, 8'h75}, e0 + 8);
    drive_push(8'h75, 1'b1, 1'b0);
    tick();
    bus.inj_valid = 1'b0;
    bus.inj_ext   = 1'b0;
    tick();
    host_key = {~host_key[10], 10'h21B};
    wait_cyc(e0 + 13);
    chk("t3_busy_done", 32'(busy), 32'd0);
    chk("t3_drain", 32'(sbq.size()), 32'd0);

    // Fill the FIFO behind a key in progress; ninth request waits for a pop
    e0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      cd = (i == 0) ? 8'h01 : 8'(32'h20 + i - 1);
      exp_ev({1'b1, 1'b0, cd}, e0 + 2 + 9 * i);
      exp_ev({1'b0, 1'b0, cd}, e0 + 7 + 9 * i);
    end
    drive_push(8'h01, 1'b0, 1'b0);
    tick();
    for (int j = 0; j < 8; j++) begin
      bus.inj_code = 8'(32'h20 + j);
      push_wait(acc);
      chk("t4_accept_edge", 32'(acc), 32'(e0 + 1 + j));
    end
    bus.inj_code = 8'h28;
    chk("t4_ready_full", 32'(bus.inj_ready), 32'd0);
    push_wait(acc);
    chk("t4_ninth_accept_edge", 32'(acc), 32'(e0 + 11));
    bus.inj_valid = 1'b0;
    wait_cyc(e0 + 92);
    chk("t4_busy_done", 32'(busy), 32'd0);
    chk("t4_drain", 32'(sbq.size()), 32'd0);

    // Flush in the second HOLD cycle with three requests queued
    e0 = cyc + 1;
    exp_ev({1'b1, 1'b0, 8'h1C}, e0 + 2);
    exp_ev({1'b0, 1'b0, 8'h1C}, e0 + 5);
    drive_push(8'h1C, 1'b0, 1'b0);
    tick();
    bus.inj_code = 8'h31;
    tick();
    bus.inj_code = 8'h32;
    tick();
    bus.inj_code = 8'h33;
    tick();
    bus.inj_code  = 8'h55;
    bus.inj_flush = 1'b1;
    tick();
    bus.inj_valid = 1'b0;
    bus.inj_flush = 1'b0;
    chk("t5_busy_kup", 32'(busy), 32'd1);
    chk("t5_ready_after_flush", 32'(bus.inj_ready), 32'd1);
    wait_cyc(e0 + 7);
    chk("t5_busy_after_gap", 32'(busy), 32'd0);
    wait_cyc(e0 + 20);
    chk("t5_busy_stays_low", 32'(busy), 32'd0);
    chk("t5_drain", 32'(sbq.size()), 32'd0);

    // Reset in the middle of HOLD: no release afterwards
    e0 = cyc + 1;
    exp_ev({1'b1, 1'b0, 8'h2A}, e0 + 2);
    drive_push(8'h2A, 1'b0, 1'b0);
    tick();
    bus.inj_valid = 1'b0;
    wait_cyc(e0 + 4);
    reset_n = 1'b0;
    exp_tgl = 1'b0;
    #1;
    chk("t6_rst_out_key", 32'(out_key), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(bus.inj_ready), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("t6_no_release", 32'(out_key), 32'd0);
    chk("t6_drain", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
